// File: rtl/burst_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// burst_scan_sequencer_if : scan configuration, acknowledge and status bundle
// Rev 1.0
// ============================================================================
interface burst_scan_sequencer_if #(
   parameter int CH_W  = 2,
   parameter int CNT_W = 20
);
   logic                 enable;
   logic                 burst_syn;
   logic [2**CH_W-1:0]   ch_mask;
   logic [7:0]           tx_width;
   logic [CNT_W-1:0]     acq_delay;
   logic [CNT_W-1:0]     acq_len;
   logic                 acq_done;
   logic [CH_W-1:0]      ch_sel;
   logic                 tx_pulse;
   logic                 acq_gate;
   logic                 busy;
   logic                 frame_done;
   logic                 overrun;
   logic                 ack_timeout;

   modport master (
      output enable, burst_syn, ch_mask, tx_width, acq_delay, acq_len, acq_done,
      input  ch_sel, tx_pulse, acq_gate, busy, frame_done, overrun, ack_timeout
   );

   modport slave (
      input  enable, burst_syn, ch_mask, tx_width, acq_delay, acq_len, acq_done,
      output ch_sel, tx_pulse, acq_gate, busy, frame_done, overrun, ack_timeout
   );
endinterface
`default_nettype wire

// File: rtl/burst_scan_sequencer.sv
`default_nettype none
// ============================================================================
// burst_scan_sequencer : per-burst TX/acquire walk over the enabled channels.
// Optional macro BURST_ACK_TIMEOUT_EN adds a 65,536-cycle acknowledge timeout.
// Rev 1.0
// ============================================================================
module burst_scan_sequencer #(
   parameter int CH_W  = 2,
   parameter int CNT_W = 20
) (
   input  wire logic             clk_sys,
   input  wire logic             reset_n,
   burst_scan_sequencer_if.slave scan_io
);
   localparam int c_n_ch = 2**CH_W;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SEL      = 3'd1,
      S_TX       = 3'd2,
      S_DELAY    = 3'd3,
      S_GATE     = 3'd4,
      S_WAIT_ACK = 3'd5,
      S_NEXT     = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic                sync_q, sync_dly_q;
   logic [c_n_ch-1:0]   mask_q, mask_d;
   logic [7:0]          txw_q, txw_d;
   logic [CNT_W-1:0]    dly_q, dly_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
   logic                tx_pulse_q, tx_pulse_d;
   logic                acq_gate_q, acq_gate_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                overrun_q, overrun_d;
   logic                ack_timeout_q, ack_timeout_d;

   logic                w_trig;
   logic [7:0]          w_txw_m1;
   logic                w_tx_last, w_dly_last, w_len_last;
   logic                w_has_next;
   logic [CH_W-1:0]     w_next_ch, w_first_ch;
   logic                w_to_expire;

   // burst_syn is registered once so a scan starts one edge after it is seen high
   assign w_trig     = sync_q & ~sync_dly_q;
   assign w_txw_m1   = (txw_q == 8'd0) ? 8'd0 : (txw_q - 8'd1);
   assign w_tx_last  = (cnt_q == CNT_W'(w_txw_m1));
   assign w_dly_last = (cnt_q == (dly_q - CNT_W'(1)));
   assign w_len_last = (cnt_q == (len_q - CNT_W'(1)));

   always_comb begin
      w_first_ch = '0;
      for (int i = c_n_ch - 1; i >= 0; i--) begin
         if (scan_io.ch_mask[i]) w_first_ch = CH_W'(i);
      end
   end

   always_comb begin
      w_next_ch  = ch_sel_q;
      w_has_next = 1'b0;
      for (int i = c_n_ch - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(ch_sel_q))) begin
            w_next_ch  = CH_W'(i);
            w_has_next = 1'b1;
         end
      end
   end

`ifdef BURST_ACK_TIMEOUT_EN
   logic [15:0] to_cnt_q, to_cnt_d;

   assign w_to_expire = (to_cnt_q == 16'hFFFF);
   assign to_cnt_d    = ((state_q == S_WAIT_ACK) && (state_d == S_WAIT_ACK))
                        ? (to_cnt_q + 16'd1) : 16'd0;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) to_cnt_q <= 16'd0;
      else          to_cnt_q <= to_cnt_d;
   end
`else
   assign w_to_expire = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      txw_d         = txw_q;
      dly_d         = dly_q;
      len_d         = len_q;
      cnt_d         = '0;
      ch_sel_d      = ch_sel_q;
      frame_done_d  = 1'b0;
      overrun_d     = 1'b0;
      ack_timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_trig && scan_io.enable) begin
               mask_d = scan_io.ch_mask;
               txw_d  = scan_io.tx_width;
               dly_d  = scan_io.acq_delay;
               len_d  = scan_io.acq_len;
               if (|scan_io.ch_mask) begin
                  state_d  = S_SEL;
                  ch_sel_d = w_first_ch;
               end
            end
         end
         S_SEL: state_d = S_TX;
         S_TX: begin
            if (!w_tx_last)          cnt_d   = cnt_q + CNT_W'(1);
            else if (dly_q != '0)    state_d = S_DELAY;
            else if (len_q != '0)    state_d = S_GATE;
            else                     state_d = S_NEXT;
         end
         S_DELAY: begin
            if (!w_dly_last)         cnt_d   = cnt_q + CNT_W'(1);
            else if (len_q != '0)    state_d = S_GATE;
            else                     state_d = S_NEXT;
         end
         S_GATE: begin
            if (!w_len_last)         cnt_d   = cnt_q + CNT_W'(1);
            else                     state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (scan_io.acq_done) begin
               state_d = S_NEXT;
            end else if (w_to_expire) begin
               state_d       = S_NEXT;
               ack_timeout_d = 1'b1;
            end
         end
         S_NEXT: begin
            if (w_has_next) begin
               state_d  = S_SEL;
               ch_sel_d = w_next_ch;
            end else begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything the scan would otherwise do this cycle
      if (state_q != S_IDLE) begin
         if (w_trig) overrun_d = 1'b1;
         if (!scan_io.enable) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            ch_sel_d      = ch_sel_q;
            frame_done_d  = 1'b0;
            ack_timeout_d = 1'b0;
         end
      end

      tx_pulse_d = (state_d == S_TX);
      acq_gate_d = (state_d == S_GATE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         sync_q        <= 1'b0;
         sync_dly_q    <= 1'b0;
         mask_q        <= '0;
         txw_q         <= 8'd0;
         dly_q         <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         ch_sel_q      <= '0;
         tx_pulse_q    <= 1'b0;
         acq_gate_q    <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         overrun_q     <= 1'b0;
         ack_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync_q        <= scan_io.burst_syn;
         sync_dly_q    <= sync_q;
         mask_q        <= mask_d;
         txw_q         <= txw_d;
         dly_q         <= dly_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         ch_sel_q      <= ch_sel_d;
         tx_pulse_q    <= tx_pulse_d;
         acq_gate_q    <= acq_gate_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         overrun_q     <= overrun_d;
         ack_timeout_q <= ack_timeout_d;
      end
   end

   assign scan_io.ch_sel      = ch_sel_q;
   assign scan_io.tx_pulse    = tx_pulse_q;
   assign scan_io.acq_gate    = acq_gate_q;
   assign scan_io.busy        = busy_q;
   assign scan_io.frame_done  = frame_done_q;
   assign scan_io.overrun     = overrun_q;
   assign scan_io.ack_timeout = ack_timeout_q;

endmodule
`default_nettype wire
